// File: rtl/phy_pkg.sv
// Shared constants for the PHY transmit path: framing bytes and the
// link-controller state encoding used by the controller and the probe.
package phy_pkg;

   localparam logic [7:0] BC_CODE_DEF   = 8'hBC;
   localparam logic [7:0] IDLE_CODE_DEF = 8'h7C;

   localparam logic [1:0] ST_RESET  = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_LOCK   = 2'd2;
   localparam logic [1:0] ST_ACTIVE = 2'd3;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-lane round-robin arbiter with a registered one-hot grant. The search
// starts at ptr and wraps upward; ptr moves past each granted lane.
module rr_arbiter4 (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] req,
   output logic [3:0] grant
);

   logic [1:0] ptr;
   logic [1:0] pick;
   logic [1:0] cand;
   logic       hit;

   // Find the first requester at or after ptr; scanning offsets high to low
   // lets the smallest offset win.
   always_comb begin
      hit  = 1'b0;
      pick = ptr;
      cand = ptr;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr + i[1:0];
         if (req[cand]) begin
            hit  = 1'b1;
            pick = cand;
         end
      end
   end

   // Register the grant; leaving the enabled window parks ptr back at lane 0.
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         grant <= 4'b0000;
         ptr   <= 2'd0;
      end else if (!enable) begin
         grant <= 4'b0000;
         ptr   <= 2'd0;
      end else if (hit) begin
         grant <= 4'b0001 << pick;
         ptr   <= pick + 2'd1;
      end else begin
         grant <= 4'b0000;
      end
   end

endmodule

// File: rtl/phy_link_ctrl.sv
// Link bring-up controller: BC-lock / IDLE handshake with a byte-strobe
// watchdog, plus round-robin lane granting while the link is active.
//
//   state  | meaning
//   RESET  | leaving reset, goes to SEARCH on the next edge
//   SEARCH | counting consecutive BC bytes, watchdog off
//   LOCK   | aligned, waiting for IDLE to finish training
//   ACTIVE | link up, lanes granted round-robin
module phy_link_ctrl
   import phy_pkg::*;
#(
   parameter logic [7:0] BC_CODE    = BC_CODE_DEF,
   parameter logic [7:0] IDLE_CODE  = IDLE_CODE_DEF,
   parameter int         LOCK_COUNT = 4,
   parameter int         WDOG_MAX   = 16
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_strobe,
   input  logic [3:0] tx_req,
   output logic       active,
   output logic       idle_out,
   output logic [3:0] grant,
   output logic       grant_valid,
   output logic [1:0] state
);

   localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
   localparam logic [8:0] WDOG_MAX9 = 9'(WDOG_MAX);

   logic [1:0] state_q, state_nx;
   logic [2:0] bc_cnt, bc_nx;
   logic [7:0] wd_cnt, wd_nx;
   logic       idle_nx;
   logic       is_bc, is_idle;
   logic       lock_hit, wd_expire, arb_en;
   logic [2:0] bc_sat;
   logic [7:0] wd_sat;
   logic [3:0] bc_inc;
   logic [8:0] wd_inc;

   assign is_bc     = rx_strobe && (rx_byte == BC_CODE);
   assign is_idle   = rx_strobe && (rx_byte == IDLE_CODE);
   assign bc_inc    = {1'b0, bc_cnt} + 4'd1;
   assign lock_hit  = (bc_inc >= LOCK_CNT4);
   assign bc_sat    = (bc_cnt == 3'd7) ? bc_cnt : bc_cnt + 3'd1;
   assign wd_inc    = {1'b0, wd_cnt} + 9'd1;
   assign wd_sat    = (wd_cnt == 8'hFF) ? wd_cnt : wd_cnt + 8'd1;
   // A strobe in the expiry cycle restarts the count instead of dropping the link.
   assign wd_expire = ((state_q == ST_LOCK) || (state_q == ST_ACTIVE))
                      && !rx_strobe && (wd_inc >= WDOG_MAX9);
   // Arbiter stops in the expiry cycle so grant clears together with active.
   assign arb_en    = (state_q == ST_ACTIVE) && !wd_expire;

   // Next-state, counter and idle-flag decode; expiry outranks strobe decode.
   always_comb begin
      state_nx = state_q;
      bc_nx    = bc_cnt;
      wd_nx    = wd_cnt;
      idle_nx  = idle_out;
      case (state_q)
         ST_RESET: begin
            state_nx = ST_SEARCH;
            bc_nx    = 3'd0;
            wd_nx    = 8'd0;
         end
         ST_SEARCH: begin
            wd_nx = 8'd0;
            if (is_bc) begin
               if (lock_hit) begin
                  state_nx = ST_LOCK;
                  bc_nx    = 3'd0;
               end else begin
                  bc_nx = bc_sat;
               end
            end else if (rx_strobe) begin
               bc_nx = 3'd0;
            end
         end
         ST_LOCK: begin
            if (wd_expire) begin
               state_nx = ST_SEARCH;
               bc_nx    = 3'd0;
               wd_nx    = 8'd0;
            end else if (rx_strobe) begin
               wd_nx = 8'd0;
               if (is_idle) begin
                  state_nx = ST_ACTIVE;
                  idle_nx  = 1'b1;
               end else if (!is_bc) begin
                  state_nx = ST_SEARCH;
                  bc_nx    = 3'd0;
               end
            end else begin
               wd_nx = wd_sat;
            end
         end
         default: begin
            if (wd_expire) begin
               state_nx = ST_SEARCH;
               bc_nx    = 3'd0;
               wd_nx    = 8'd0;
            end else if (rx_strobe) begin
               wd_nx   = 8'd0;
               idle_nx = is_idle;
            end else begin
               wd_nx = wd_sat;
            end
         end
      endcase
      if (state_nx != ST_ACTIVE) idle_nx = 1'b0;
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RESET;
         bc_cnt      <= 3'd0;
         wd_cnt      <= 8'd0;
         idle_out    <= 1'b0;
         active      <= 1'b0;
         grant_valid <= 1'b0;
      end else begin
         state_q     <= state_nx;
         bc_cnt      <= bc_nx;
         wd_cnt      <= wd_nx;
         idle_out    <= idle_nx;
         active      <= (state_nx == ST_ACTIVE);
         grant_valid <= arb_en && (|tx_req);
      end
   end

   assign state = state_q;

   rr_arbiter4 u_arb (
      .clk_4f (clk_4f),
      .reset  (reset),
      .enable (arb_en),
      .req    (tx_req),
      .grant  (grant)
   );

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Scoreboard bench for phy_link_ctrl: each driven cycle queues its expected
// outputs, and a monitor compares after every edge or asynchronous reset.
module tb_phy_link_ctrl;
   import phy_pkg::*;

   logic       clk_4f = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_strobe = 1'b0;
   logic [3:0] tx_req = 4'h0;
   logic       active, idle_out, grant_valid;
   logic [3:0] grant;
   logic [1:0] state;

   typedef struct packed {
      logic [1:0] st;
      logic       idl;
      logic [3:0] gnt;
   } exp_t;

   exp_t sb[$];
   int   tags[$];
   int   total = 0;
   int   bad = 0;
   int   step_no = 0;

   localparam logic [7:0] BC = 8'hBC;
   localparam logic [7:0] ID = 8'h7C;

   phy_link_ctrl dut (
      .clk_4f      (clk_4f),
      .reset       (reset),
      .rx_byte     (rx_byte),
      .rx_strobe   (rx_strobe),
      .tx_req      (tx_req),
      .active      (active),
      .idle_out    (idle_out),
      .grant       (grant),
      .grant_valid (grant_valid),
      .state       (state)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic check(input string name, input int tag, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%0h want=%0h", name, tag, act, exp);
      end
   endtask

   // Monitor: compare whatever the driver queued for this edge/reset event.
   initial begin
      exp_t e;
      int   tag;
      forever begin
         @(posedge clk_4f or negedge reset);
         #1;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            tag = tags.pop_front();
            check("state", tag, {2'b00, state}, {2'b00, e.st});
            check("active", tag, {3'b000, active}, {3'b000, (e.st == ST_ACTIVE)});
            check("idle_out", tag, {3'b000, idle_out}, {3'b000, e.idl});
            check("grant", tag, grant, e.gnt);
            check("grant_valid", tag, {3'b000, grant_valid}, {3'b000, |e.gnt});
         end
      end
   end

   task automatic expect_push(input logic [1:0] es, input logic ei, input logic [3:0] eg);
      step_no++;
      sb.push_back(exp_t'{es, ei, eg});
      tags.push_back(step_no);
   endtask

   task automatic step(input logic stb, input logic [7:0] b, input logic [3:0] req,
                       input logic [1:0] es, input logic ei, input logic [3:0] eg);
      @(negedge clk_4f);
      rx_strobe = stb;
      rx_byte   = b;
      tx_req    = req;
      expect_push(es, ei, eg);
   endtask

   task automatic release_rst();
      @(negedge clk_4f);
      reset     = 1'b1;
      rx_strobe = 1'b0;
      tx_req    = 4'h0;
      expect_push(ST_SEARCH, 1'b0, 4'h0);
   endtask

   task automatic mid_reset();
      @(posedge clk_4f);
      #3;
      expect_push(ST_RESET, 1'b0, 4'h0);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      // Held in reset: inputs are ignored.
      step(0, 8'h00, 4'h0, ST_RESET, 0, 4'h0);
      step(1, BC, 4'hF, ST_RESET, 0, 4'h0);
      release_rst();

      // Basic bring-up.
      for (int i = 0; i < 3; i++) step(1, BC, 4'h0, ST_SEARCH, 0, 4'h0);
      step(1, BC, 4'h0, ST_LOCK, 0, 4'h0);
      step(1, ID, 4'h0, ST_ACTIVE, 1, 4'h0);

      // Round-robin rotation, then ptr hold with no requests.
      step(0, 8'h00, 4'b1011, ST_ACTIVE, 1, 4'b0001);
      step(0, 8'h00, 4'b1011, ST_ACTIVE, 1, 4'b0010);
      step(0, 8'h00, 4'b1011, ST_ACTIVE, 1, 4'b1000);
      step(0, 8'h00, 4'b1011, ST_ACTIVE, 1, 4'b0001);
      step(0, 8'h00, 4'b0000, ST_ACTIVE, 1, 4'b0000);
      step(0, 8'h00, 4'b1011, ST_ACTIVE, 1, 4'b0010);

      // idle_out follows the last accepted byte.
      step(1, 8'h00, 4'h0, ST_ACTIVE, 0, 4'h0);
      step(1, ID, 4'h0, ST_ACTIVE, 1, 4'h0);

      // Watchdog expiry exactly 16 cycles after the last strobe.
      for (int k = 1; k <= 15; k++) step(0, 8'h00, 4'b0100, ST_ACTIVE, 1, 4'b0100);
      step(0, 8'h00, 4'b0100, ST_SEARCH, 0, 4'h0);

      // bc_cnt clears on a non-BC byte in SEARCH.
      step(1, BC, 4'h0, ST_SEARCH, 0, 4'h0);
      step(1, BC, 4'h0, ST_SEARCH, 0, 4'h0);
      step(1, 8'h00, 4'h0, ST_SEARCH, 0, 4'h0);
      for (int i = 0; i < 3; i++) step(1, BC, 4'h0, ST_SEARCH, 0, 4'h0);
      step(1, BC, 4'h0, ST_LOCK, 0, 4'h0);

      // Bad byte in LOCK drops back to SEARCH; bring-up recovers.
      step(1, 8'h55, 4'h0, ST_SEARCH, 0, 4'h0);
      for (int i = 0; i < 3; i++) step(1, BC, 4'h0, ST_SEARCH, 0, 4'h0);
      step(1, BC, 4'h0, ST_LOCK, 0, 4'h0);
      step(1, BC, 4'h0, ST_LOCK, 0, 4'h0);
      step(1, ID, 4'h0, ST_ACTIVE, 1, 4'h0);

      // Strobe in the would-be expiry cycle keeps the link up.
      for (int k = 1; k <= 15; k++) step(0, 8'h00, 4'h0, ST_ACTIVE, 1, 4'h0);
      step(1, 8'h00, 4'h0, ST_ACTIVE, 0, 4'h0);

      // Reset mid-traffic.
      step(0, 8'h00, 4'hF, ST_ACTIVE, 0, 4'b0001);
      step(0, 8'h00, 4'hF, ST_ACTIVE, 0, 4'b0010);
      mid_reset();
      @(negedge clk_4f);
      @(negedge clk_4f);
      release_rst();
      step(0, 8'h00, 4'hF, ST_SEARCH, 0, 4'h0);

      for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk_4f);
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
